fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Holds the PC, drives the instruction-memory port, and presents a registered instruction (opcode/funct split out) to the main decoder.
- Consumes the decoder's Branch/Jump/SyscallSrc outputs for the instruction in IF/ID to redirect the PC, flush it, or halt it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 10, word-address width driven on imem_addr.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_req  out  1  fetch request, combinational from state
- imem_ready  in  1  imem_rdata valid for current imem_addr this cycle
- imem_rdata  in  32  instruction word
- stall  in  1  hazard unit: hold PC and IF/ID
- ctrl_branch  in  2  decoder Branch (00 none, 01 beq, 10 bne)
- ctrl_jump  in  2  decoder Jump (00 none, 01 jr, 10 jal, 11 j)
- ctrl_syscall  in  1  decoder SyscallSrc
- rs_eq_rt  in  1  ID-stage register comparator result
- rs_value  in  32  forwarded rs, jr target
- resume  in  1  one-cycle pulse: leave HALT
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  32  registered instruction
- if_id_opcode  out  6  if_id_instr[31:26]
- if_id_funct  out  6  if_id_instr[5:0]
- if_id_pc4  out  32  PC+4 of the IF/ID instruction
- halted  out  1  state == HALT

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc4=0, halted=0, pending=0. imem_req=0 during the reset cycle.
- States: FETCH, HALT. imem_req=1 in FETCH, 0 in HALT.
- id_act = if_id_valid & ~stall. Decoder inputs are ignored unless id_act.
- taken = id_act & ((branch==01 & rs_eq_rt) | (branch==10 & ~rs_eq_rt) | jump!=00).
- Target: beq/bne = if_id_pc4 + (sext(instr[15:0])<<2). j/jal = {if_id_pc4[31:28], instr[25:0], 2'b00}. jr = rs_value. Arithmetic is 32-bit and wraps.
- Per-cycle priority: rst > syscall > taken > stall > fetch.
- Syscall: if id_act & ctrl_syscall, go to HALT and set if_id_valid<=0. PC is held at the instruction after the syscall.
- Taken: pc<=target and if_id_valid<=0 (one-bubble flush of the wrong-path fetch).
- Stall without taken: pc and all IF/ID registers hold, including valid.
- Fetch, imem_ready=1: IF/ID<={rdata, pc+4}, valid<=1, pc<=pc+4.
- Fetch, imem_ready=0: valid<=0 (bubble), pc holds, address stays stable until ready.
- HALT: IF/ID valid=0 and pc holds. resume moves to FETCH next cycle. resume in FETCH is ignored. Decoder inputs are ignored in HALT.
- stall with imem_ready=1: the fetched word is discarded and refetched later; imem must tolerate repeat reads.
- Reset mid-wait or in HALT: all state returns to reset values next edge.

Optional Feature:
- Macro: FETCH_DELAY_SLOT_EN.
- Defined: MIPS branch delay slot.
  - On taken, the instruction at the current pc is not flushed.
  - If imem_ready that cycle: IF/ID<=slot (valid=1), pc<=target.
  - Else: latch target in pending_pc and set pending=1. The next successful fetch captures the slot, loads pc<=pending_pc and clears pending.
  - A taken while pending is impossible and need not be handled.
  - Syscall still flushes.
- Undefined: flush semantics as above; pending logic is absent.

Decomposition:
- Package fetch_pkg holds:
  - Branch encodings BR_NONE/BR_BEQ/BR_BNE (00/01/10), matching decoder encodings.
  - Jump encodings JMP_NONE/JMP_JR/JMP_JAL/JMP_J (00/01/10/11), matching decoder encodings.
  - fetch_state_t enum {FETCH, HALT}.
  - Constant INSTR_W=32.
- Sub-module next_pc_calc: combinational taken + target from ctrl_*, if_id_instr, if_id_pc4, rs_eq_rt, rs_value.

Test Plan:
- Reset, imem_ready=1, sequential words at 0x0,0x4,0x8 -> imem_addr 0,1,2. if_id_valid first high the cycle after reset release, if_id_pc4=0x4 then 0x8.
- beq at pc 0x10, imm=0x0003, rs_eq_rt=1 -> next pc=0x20, one bubble (valid=0), then instr from 0x20. With rs_eq_rt=0 -> no redirect.
- j with index 0x0000040, if_id_pc4=0x1000_0008 -> pc=0x1000_0100. jr with rs_value=0x0000_0044 -> pc=0x44.
- stall=1 for 3 cycles while taken bne pending -> pc and IF/ID frozen, no redirect. Stall drops -> redirect to target.
- syscall at pc 0x8 -> halted=1 next cycle, imem_req=0, pc=0xC held 5 cycles. resume pulse -> fetch resumes at 0xC.
- FETCH_DELAY_SLOT_EN, j taken with imem_ready=0 for 2 cycles -> slot at pc+4 captured valid when ready, then fetch at target; no bubble for the slot.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings and helpers for the instruction-fetch stage.
// Branch/jump encodings mirror the main decoder's control outputs.
package fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_JR   = 2'b01;
  localparam logic [1:0] JMP_JAL  = 2'b10;
  localparam logic [1:0] JMP_J    = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  // Branch displacement: sign-extended word offset turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_next_pc_calc.sv
// Redirect decision and target address for the instruction held in IF/ID.
// Purely combinational; id_act gates every redirect.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic        id_act,
  input  logic [1:0]  ctrl_branch,
  input  logic [1:0]  ctrl_jump,
  input  logic        rs_eq_rt,
  input  logic [31:0] rs_value,
  input  logic [25:0] instr_index,
  input  logic [31:0] pc4,
  output logic        taken,
  output logic [31:0] target
);

  logic [31:0] branch_target_s;
  logic [31:0] jump_target_s;
  logic        redirect_s;

  assign branch_target_s = pc4 + branch_offset(instr_index[15:0]);
  assign jump_target_s   = {pc4[31:28], instr_index, 2'b00};

  // Select redirect condition and target; a jump overrides any branch field.
  always_comb begin
    redirect_s = 1'b0;
    target     = branch_target_s;
    case (ctrl_jump)
      JMP_NONE: begin
        case (ctrl_branch)
          BR_BEQ:  redirect_s = rs_eq_rt;
          BR_BNE:  redirect_s = ~rs_eq_rt;
          BR_NONE: redirect_s = 1'b0;
          default: redirect_s = 1'b0;
        endcase
        target = branch_target_s;
      end
      JMP_JR: begin
        redirect_s = 1'b1;
        target     = rs_value;
      end
      JMP_JAL, JMP_J: begin
        redirect_s = 1'b1;
        target     = jump_target_s;
      end
      default: begin
        redirect_s = 1'b0;
        target     = branch_target_s;
      end
    endcase
  end

  assign taken = id_act & redirect_s;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, imem port, IF/ID register and syscall HALT.
// Optional MIPS branch delay slot is enabled by defining FETCH_DELAY_SLOT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic [1:0]         ctrl_branch,
  input  logic [1:0]         ctrl_jump,
  input  logic               ctrl_syscall,
  input  logic               rs_eq_rt,
  input  logic [31:0]        rs_value,
  input  logic               resume,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [5:0]         if_id_opcode,
  output logic [5:0]         if_id_funct,
  output logic [31:0]        if_id_pc4,
  output logic               halted
);

  fetch_state_t        state_r, state_s;
  logic [31:0]         pc_r, pc_s;
  logic                valid_r, valid_s;
  logic [INSTR_W-1:0]  instr_r, instr_s;
  logic [31:0]         pc4_r, pc4_s;
`ifdef FETCH_DELAY_SLOT_EN
  logic                pending_r, pending_s;
  logic [31:0]         pending_pc_r, pending_pc_s;
`endif

  logic        id_act_s;
  logic        taken_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  assign id_act_s   = valid_r & ~stall & (state_r == FETCH);
  assign pc_plus4_s = pc_r + 32'd4;

  next_pc_calc u_next_pc (
    .id_act      (id_act_s),
    .ctrl_branch (ctrl_branch),
    .ctrl_jump   (ctrl_jump),
    .rs_eq_rt    (rs_eq_rt),
    .rs_value    (rs_value),
    .instr_index (instr_r[25:0]),
    .pc4         (pc4_r),
    .taken       (taken_s),
    .target      (target_s)
  );

  // Next-state logic: syscall > taken > stall > fetch, HALT waits for resume.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    valid_s = valid_r;
    instr_s = instr_r;
    pc4_s   = pc4_r;
`ifdef FETCH_DELAY_SLOT_EN
    pending_s    = pending_r;
    pending_pc_s = pending_pc_r;
`endif
    case (state_r)
      FETCH: begin
        if (id_act_s && ctrl_syscall) begin
          state_s = HALT;
          valid_s = 1'b0;
        end else if (taken_s) begin
`ifdef FETCH_DELAY_SLOT_EN
          // The word at pc is the delay slot and survives the redirect.
          if (imem_ready) begin
            instr_s = imem_rdata;
            pc4_s   = pc_plus4_s;
            valid_s = 1'b1;
            pc_s    = target_s;
          end else begin
            pending_pc_s = target_s;
            pending_s    = 1'b1;
            valid_s      = 1'b0;
          end
`else
          pc_s    = target_s;
          valid_s = 1'b0;
`endif
        end else if (stall) begin
          pc_s    = pc_r;
          valid_s = valid_r;
        end else if (imem_ready) begin
          instr_s = imem_rdata;
          pc4_s   = pc_plus4_s;
          valid_s = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
          pc_s      = pending_r ? pending_pc_r : pc_plus4_s;
          pending_s = 1'b0;
`else
          pc_s    = pc_plus4_s;
`endif
        end else begin
          valid_s = 1'b0;
        end
      end
      HALT: begin
        valid_s = 1'b0;
        state_s = resume ? FETCH : HALT;
      end
      default: begin
        state_s = FETCH;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
      pc_r    <= RESET_PC;
      valid_r <= 1'b0;
      instr_r <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
`ifdef FETCH_DELAY_SLOT_EN
      pending_r    <= 1'b0;
      pending_pc_r <= 32'h0000_0000;
`endif
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      valid_r <= valid_s;
      instr_r <= instr_s;
      pc4_r   <= pc4_s;
`ifdef FETCH_DELAY_SLOT_EN
      pending_r    <= pending_s;
      pending_pc_r <= pending_pc_s;
`endif
    end
  end

  assign imem_addr    = pc_r[IMEM_AW+1:2];
  assign imem_req     = (state_r == FETCH) & ~rst;
  assign if_id_valid  = valid_r;
  assign if_id_instr  = instr_r;
  assign if_id_opcode = instr_r[31:26];
  assign if_id_funct  = instr_r[5:0];
  assign if_id_pc4    = pc4_r;
  assign halted       = (state_r == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a word-addressed imem model and a small
// decoder model feed the DUT; expected (pc4, instr) pairs are queued per test.
module tb_fetch_stage;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit SLOT = 1'b1;
`else
  localparam bit SLOT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  ctrl_branch;
  logic [1:0]  ctrl_jump;
  logic        ctrl_syscall;
  logic        rs_eq_rt;
  logic [31:0] rs_value;
  logic        resume;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [5:0]  if_id_opcode;
  logic [5:0]  if_id_funct;
  logic [31:0] if_id_pc4;
  logic        halted;

  logic [31:0] mem [0:1023];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;

  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_BNE  = 32'h1422_0004;
  localparam logic [31:0] I_J40  = 32'h0800_0040;
  localparam logic [31:0] I_J20  = 32'h0800_0020;
  localparam logic [31:0] I_JR   = 32'h0020_0008;
  localparam logic [31:0] I_SYS  = 32'h0000_000C;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .ctrl_branch  (ctrl_branch),
    .ctrl_jump    (ctrl_jump),
    .ctrl_syscall (ctrl_syscall),
    .rs_eq_rt     (rs_eq_rt),
    .rs_value     (rs_value),
    .resume       (resume),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_opcode (if_id_opcode),
    .if_id_funct  (if_id_funct),
    .if_id_pc4    (if_id_pc4),
    .halted       (halted)
  );

  function automatic logic [31:0] mk(input int idx);
    return 32'h2000_0000 + 32'(idx);
  endfunction

  function automatic exp_t ex(input logic [31:0] pc4, input logic [31:0] instr);
    exp_t e;
    e.pc4 = pc4;
    e.instr = instr;
    return e;
  endfunction

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) mem[i] = mk(i);
  endtask

  // One clock: sample point is 1 time unit after the edge; imem and decoder respond.
  task automatic advance();
    @(posedge clk);
    #1;
    imem_rdata   = mem[imem_addr];
    ctrl_branch  = 2'b00;
    ctrl_jump    = 2'b00;
    ctrl_syscall = 1'b0;
    if (if_id_valid) begin
      case (if_id_instr[31:26])
        6'h04: ctrl_branch = 2'b01;
        6'h05: ctrl_branch = 2'b10;
        6'h02: ctrl_jump   = 2'b11;
        6'h03: ctrl_jump   = 2'b10;
        6'h00: begin
          if (if_id_instr[5:0] == 6'h08) ctrl_jump = 2'b01;
          if (if_id_instr[5:0] == 6'h0C) ctrl_syscall = 1'b1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1; resume = 1'b0;
    advance();
    advance();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    load_prog();
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1; resume = 1'b0;
    advance();
    checks++;
    if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc4 !== 32'h0 || halted !== 1'b0 || imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h halted=%b addr=%0d, required 0,0,0,0,0,0",
               imem_req, if_id_valid, if_id_instr, if_id_pc4, halted, imem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin
      failures++;
      $display("FAIL reset_release: req=%b addr=%0d, required req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    load_prog();
    do_reset();
    sb.push_back(ex(32'h4, mk(0)));
    sb.push_back(ex(32'h8, mk(1)));
    sb.push_back(ex(32'hC, mk(2)));
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      advance();
      checks++;
      if (imem_addr !== 10'(c + 1) || if_id_valid !== 1'b1) begin
        failures++;
        $display("FAIL seq_addr: cycle %0d addr=%0d valid=%b, required addr=%0d valid=1", c, imem_addr, if_id_valid, c + 1);
      end
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL seq_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL seq_timeout: %0d entries left, required 0", sb.size());
    end
  endtask

  task automatic test_wait();
    exp_t e;
    load_prog();
    do_reset();
    sb.push_back(ex(32'h4, mk(0)));
    sb.push_back(ex(32'h8, mk(1)));
    sb.push_back(ex(32'hC, mk(2)));
    sb.push_back(ex(32'h10, mk(3)));
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      advance();
      imem_ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
      if (c == 2 || c == 3) begin
        checks++;
        if (if_id_valid !== 1'b0 || imem_addr !== 10'd2) begin
          failures++;
          $display("FAIL wait_bubble: cycle %0d valid=%b addr=%0d, required valid=0 addr=2", c, if_id_valid, imem_addr);
        end
      end
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL wait_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
      end
    end
    imem_ready = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wait_timeout: %0d entries left, required 0", sb.size());
    end
  endtask

  task automatic test_branch(input logic eq);
    exp_t e;
    bit   after_beq;
    load_prog();
    mem[4] = I_BEQ;
    rs_eq_rt = eq;
    do_reset();
    after_beq = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(ex(32'(4 * (i + 1)), mk(i)));
    sb.push_back(ex(32'h14, I_BEQ));
    if (eq) begin
      if (SLOT) sb.push_back(ex(32'h18, mk(5)));
      sb.push_back(ex(32'h24, mk(8)));
      sb.push_back(ex(32'h28, mk(9)));
    end else begin
      sb.push_back(ex(32'h18, mk(5)));
      sb.push_back(ex(32'h1C, mk(6)));
    end
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      advance();
      if (after_beq) begin
        after_beq = 1'b0;
        checks++;
        if (if_id_valid !== (SLOT | ~eq)) begin
          failures++;
          $display("FAIL beq_bubble: eq=%b valid=%b, required %b", eq, if_id_valid, SLOT | ~eq);
        end
      end
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL beq_sb: eq=%b pc4=%h instr=%h, required pc4=%h instr=%h", eq, if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
        if (e.instr == I_BEQ) after_beq = 1'b1;
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL beq_timeout: eq=%b %0d entries left, required 0", eq, sb.size());
    end
  endtask

  task automatic test_stall_bne();
    exp_t e;
    int   stall_cnt;
    load_prog();
    mem[1] = I_BNE;
    rs_eq_rt = 1'b0;
    do_reset();
    stall_cnt = 0;
    sb.push_back(ex(32'h4, mk(0)));
    sb.push_back(ex(32'h8, I_BNE));
    if (SLOT) sb.push_back(ex(32'hC, mk(2)));
    sb.push_back(ex(32'h1C, mk(6)));
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      advance();
      if (if_id_valid && if_id_instr == I_BNE) begin
        checks++;
        if (imem_addr !== 10'd2 || if_id_pc4 !== 32'h8) begin
          failures++;
          $display("FAIL stall_freeze: addr=%0d pc4=%h, required addr=2 pc4=00000008", imem_addr, if_id_pc4);
        end
        stall = (stall_cnt < 3) ? 1'b1 : 1'b0;
        if (stall_cnt < 3) stall_cnt++;
      end else begin
        stall = 1'b0;
      end
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL stall_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
      end
    end
    stall = 1'b0;
    checks++;
    if (sb.size() != 0 || stall_cnt != 3) begin
      failures++;
      $display("FAIL stall_timeout: left=%0d stalls=%0d, required left=0 stalls=3", sb.size(), stall_cnt);
    end
  endtask

  task automatic test_jumps();
    exp_t e;
    load_prog();
    mem[1] = I_JR;
    mem[3] = I_J40;
    rs_value = 32'h1000_000C;
    do_reset();
    sb.push_back(ex(32'h4, mk(0)));
    sb.push_back(ex(32'h8, I_JR));
    if (SLOT) sb.push_back(ex(32'hC, mk(2)));
    sb.push_back(ex(32'h1000_0010, I_J40));
    if (SLOT) sb.push_back(ex(32'h1000_0014, mk(4)));
    sb.push_back(ex(32'h1000_0104, mk(64)));
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      advance();
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL jump_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL jump_timeout: %0d entries left, required 0", sb.size());
    end
  endtask

  task automatic test_syscall();
    exp_t e;
    load_prog();
    mem[2] = I_SYS;
    do_reset();
    sb.push_back(ex(32'h4, mk(0)));
    sb.push_back(ex(32'h8, mk(1)));
    sb.push_back(ex(32'hC, I_SYS));
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      advance();
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL sys_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      advance();
      checks++;
      if (halted !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 10'd3) begin
        failures++;
        $display("FAIL sys_halt: cycle %0d halted=%b req=%b valid=%b addr=%0d, required 1,0,0,3",
                 c, halted, imem_req, if_id_valid, imem_addr);
      end
    end
    resume = 1'b1;
    advance();
    resume = 1'b0;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'd3) begin
      failures++;
      $display("FAIL sys_resume: halted=%b req=%b addr=%0d, required 0,1,3", halted, imem_req, imem_addr);
    end
    sb.push_back(ex(32'h10, mk(3)));
    sb.push_back(ex(32'h14, mk(4)));
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      advance();
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL sys_resume_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sys_timeout: %0d entries left, required 0", sb.size());
    end
  endtask

  task automatic test_reset_in_halt();
    int n;
    load_prog();
    mem[1] = I_SYS;
    do_reset();
    n = 0;
    while (!halted && n < 20) begin
      advance();
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL rst_halt_reach: halted=%b after %0d cycles, required 1", halted, n);
    end
    rst = 1'b1;
    advance();
    checks++;
    if (halted !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 10'd0 || if_id_pc4 !== 32'h0) begin
      failures++;
      $display("FAIL rst_halt: halted=%b valid=%b addr=%0d pc4=%h, required 0,0,0,00000000",
               halted, if_id_valid, imem_addr, if_id_pc4);
    end
    rst = 1'b0;
  endtask

`ifdef FETCH_DELAY_SLOT_EN
  task automatic test_delay_slot();
    exp_t e;
    int   wait_cnt;
    bit   armed;
    bit   after_slot;
    load_prog();
    mem[1] = I_J20;
    do_reset();
    wait_cnt = 0;
    armed = 1'b0;
    after_slot = 1'b0;
    sb.push_back(ex(32'h4, mk(0)));
    sb.push_back(ex(32'h8, I_J20));
    sb.push_back(ex(32'hC, mk(2)));
    sb.push_back(ex(32'h84, mk(32)));
    for (int c = 0; c < 30 && sb.size() > 0; c++) begin
      advance();
      if (after_slot) begin
        after_slot = 1'b0;
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc4 !== 32'h84) begin
          failures++;
          $display("FAIL slot_target: valid=%b pc4=%h, required valid=1 pc4=00000084", if_id_valid, if_id_pc4);
        end
      end
      if (if_id_valid && if_id_instr == I_J20 && !armed) begin
        armed = 1'b1;
        wait_cnt = 2;
      end
      imem_ready = (wait_cnt > 0) ? 1'b0 : 1'b1;
      if (wait_cnt > 0) wait_cnt--;
      if (if_id_valid && !stall) begin
        e = sb.pop_front();
        checks++;
        if (if_id_pc4 !== e.pc4 || if_id_instr !== e.instr) begin
          failures++;
          $display("FAIL slot_sb: pc4=%h instr=%h, required pc4=%h instr=%h", if_id_pc4, if_id_instr, e.pc4, e.instr);
        end
        if (e.instr == mk(2)) after_slot = 1'b1;
      end
    end
    imem_ready = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL slot_timeout: %0d entries left, required 0", sb.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1; resume = 1'b0;
    rs_eq_rt = 1'b0; rs_value = 32'h0; imem_rdata = 32'h0;
    ctrl_branch = 2'b00; ctrl_jump = 2'b00; ctrl_syscall = 1'b0;
    test_reset();
    test_sequential();
    test_wait();
    test_branch(1'b1);
    test_branch(1'b0);
    test_stall_bne();
    test_jumps();
    test_syscall();
    test_reset_in_halt();
`ifdef FETCH_DELAY_SLOT_EN
    test_delay_slot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
